fft_r2_sequencer: RTL

// - Parametrised radix-2 DIT control sequencer for in-place N-point FFT; successor to fixed-size FFT_N control.
// - Issues one butterfly per cycle: read address pair, twiddle ROM address, delayed write-back pair for shared pipelined FP adder/mult lanes.
// - Sits between the sample RAM, cos/sin twiddle ROM and arithmetic datapath; contains no datapath arithmetic itself.

---
 rtl/fft_seq_pkg.sv | 24 ++
 rtl/fft_delay_line.sv | 26 ++
 rtl/fft_r2_sequencer.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/fft_seq_pkg.sv
// Shared types and width helpers for the radix-2 FFT control sequencer.
package fft_seq_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain,
    StDone
  } seq_state_e;

  localparam int unsigned PipeLatMin = 1;
  localparam int unsigned PipeLatMax = 31;
  localparam int unsigned DrainCntW  = $clog2(PipeLatMax + 1);

  function automatic int unsigned stage_width(int unsigned log2n);
    return $clog2(log2n + 1);
  endfunction

  // Delay-line word: {wr_en, wr_addr_a, wr_addr_b}
  function automatic int unsigned delay_width(int unsigned aw);
    return 2 * aw + 1;
  endfunction

endpackage

// File: rtl/fft_delay_line.sv
// Fixed-depth shift register with synchronous clear and shift enable.
module fft_delay_line #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] pipe_q [DEPTH];

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < int'(DEPTH); i++) pipe_q[i] <= '0;
    end else if (en) begin
      pipe_q[0] <= din;
      for (int i = 1; i < int'(DEPTH); i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign dout = pipe_q[DEPTH-1];

endmodule

// File: rtl/fft_r2_sequencer.sv
// Radix-2 DIT in-place FFT sequencer: butterfly address/twiddle issue plus delayed write-back.
// Optional FFT_STALL_EN adds a stall input that freezes the whole sequencer outside idle.
module fft_r2_sequencer
  import fft_seq_pkg::*;
#(
  parameter int unsigned LOG2N    = 7,
  parameter int unsigned PIPE_LAT = 6,
  parameter int unsigned AW       = LOG2N
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
`ifdef FFT_STALL_EN
  input  logic                          stall,
`endif
  output logic                          ready,
  output logic                          busy,
  output logic                          rd_en,
  output logic [AW-1:0]                 rd_addr_a,
  output logic [AW-1:0]                 rd_addr_b,
  output logic [AW-2:0]                 tw_addr,
  output logic [stage_width(LOG2N)-1:0] stage,
  output logic                          wr_en,
  output logic [AW-1:0]                 wr_addr_a,
  output logic [AW-1:0]                 wr_addr_b,
  output logic                          done
);

  localparam int unsigned SW = stage_width(LOG2N);
  localparam int unsigned JW = LOG2N - 1;
  localparam int unsigned DW = delay_width(AW);

  localparam logic [JW-1:0]        JLast     = '1;
  localparam logic [SW-1:0]        LastStage = SW'(LOG2N - 1);
  localparam logic [DrainCntW-1:0] DrainLast = DrainCntW'(PIPE_LAT - 1);

  seq_state_e           state_q, state_d;
  logic [JW-1:0]        j_q, j_d;
  logic [SW-1:0]        stage_q, stage_d;
  logic [DrainCntW-1:0] cnt_q, cnt_d;
  logic [AW-1:0]        addr_a_q, addr_a_d, addr_b_q, addr_b_d;
  logic [AW-2:0]        tw_q, tw_d;
  logic                 hold;
  logic                 load;

  logic [AW-1:0] jx, mask, pos, half;
  logic [DW-1:0] dl_in, dl_out;

`ifdef FFT_STALL_EN
  assign hold = stall && (state_q != StIdle);
`else
  assign hold = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    j_d     = j_q;
    stage_d = stage_q;
    cnt_d   = cnt_q;
    if (!hold) begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_d = StIssue;
            j_d     = '0;
            stage_d = '0;
          end
        end
        StIssue: begin
          if (j_q == JLast) begin
            state_d = StDrain;
            j_d     = '0;
            cnt_d   = '0;
          end else begin
            j_d = j_q + JW'(1);
          end
        end
        StDrain: begin
          if (cnt_q == DrainLast) begin
            if (stage_q == LastStage) begin
              state_d = StDone;
            end else begin
              state_d = StIssue;
              stage_d = stage_q + SW'(1);
            end
          end else begin
            cnt_d = cnt_q + DrainCntW'(1);
          end
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // Addresses for the butterfly issued next cycle, derived from the next-state counters.
  always_comb begin
    jx       = {1'b0, j_d};
    mask     = ~({AW{1'b1}} << stage_d);
    pos      = jx & mask;
    half     = AW'(1) << stage_d;
    addr_a_d = ((jx >> stage_d) << (stage_d + SW'(1))) | pos;
    addr_b_d = addr_a_d + half;
    tw_d     = pos[AW-2:0] << (LastStage - stage_d);
    load     = !hold && (state_d == StIssue);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      j_q      <= '0;
      stage_q  <= '0;
      cnt_q    <= '0;
      addr_a_q <= '0;
      addr_b_q <= '0;
      tw_q     <= '0;
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
      if (load) begin
        addr_a_q <= addr_a_d;
        addr_b_q <= addr_b_d;
        tw_q     <= tw_d;
      end
    end
  end

  assign dl_in = {state_q == StIssue, addr_a_q, addr_b_q};

  fft_delay_line #(
    .WIDTH (DW),
    .DEPTH (PIPE_LAT)
  ) u_wr_pipe (
    .clk  (clk),
    .clr  (rst),
    .en   (!hold),
    .din  (dl_in),
    .dout (dl_out)
  );

  assign ready     = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign rd_en     = (state_q == StIssue) && !hold;
  assign rd_addr_a = addr_a_q;
  assign rd_addr_b = addr_b_q;
  assign tw_addr   = tw_q;
  assign stage     = stage_q;
  assign wr_en     = dl_out[DW-1] && !hold;
  assign wr_addr_a = dl_out[2*AW-1:AW];
  assign wr_addr_b = dl_out[AW-1:0];
  // A stalled done stays pending in StDone and fires on release.
  assign done      = (state_q == StDone) && !hold;

endmodule
